cheri_trvk_sched: RTL and testbench

- Sequences the register file's tag-reservation (trsv) and tag-revocation (trvk) ports for pipelined load-capability revocation checking.
- For every capability load it reserves the destination register and queues a check.
- The queued check reads the revocation bitmap over a req/gnt/rvalid memory port, then releases the register through trvk, clearing its tag if the bit is set.
- Sits between the load/store unit writeback and the register file.

---
 rtl/cheri_pkg.sv | 23 ++
 rtl/cheri_trvk_fifo.sv | 65 ++++++
 rtl/prim_secded_inv_39_32_enc.sv | 23 ++
 rtl/cheri_trvk_sched.sv | 176 +++++++++++++++++
 tb/tb_cheri_trvk_sched.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cheri_pkg.sv
// Shared types for the capability-load revocation scheduler.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Holds FSM encoding, queued-check entry layout and the all-zero parity word.
package cheri_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RVK  = 2'd3
    } trvk_sched_state_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] base;
        logic        tag;
        logic        inrange;
    } rvk_entry_t;

    // Inverted-SECDED check bits of an all-zero data word.
    localparam logic [6:0] TrvkNullPar = 7'h2a;

endpackage

// File: rtl/cheri_trvk_fifo.sv
// Pending-check queue with a per-entry destination-register match vector.
// Latency: pushed entry visible at head the next cycle. Backpressure: full flag; caller must not push when full.
// Simultaneous push and pop are allowed whenever the queue is neither empty (for pop) nor full (for push).
module cheri_trvk_fifo
    import cheri_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  rvk_entry_t       push_dat,
    input  logic             pop,
    output rvk_entry_t       head,
    output logic             full,
    output logic             empty,
    input  logic [4:0]       match_rd,
    output logic [Depth-1:0] match
);

    localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

    rvk_entry_t       mem_q [Depth];
    logic [Depth-1:0] vld_q, vld_d;
    logic [AW-1:0]    wptr_q, rptr_q;

    always_comb begin
        vld_d = vld_q;
        if (pop) begin
            vld_d[rptr_q] = 1'b0;
        end
        if (push) begin
            vld_d[wptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            vld_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            if (push) begin
                mem_q[wptr_q] <= push_dat;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    assign head  = mem_q[rptr_q];
    assign full  = &vld_q;
    assign empty = ~|vld_q;

    for (genvar g = 0; g < Depth; g++) begin : g_match
        assign match[g] = vld_q[g] && (mem_q[g].rd == match_rd);
    end

endmodule

// File: rtl/prim_secded_inv_39_32_enc.sv
// Inverted Hsiao SECDED(39,32) encoder; check bits in [38:32].
// Latency: combinational. Backpressure: none.
// Parity bits are XORed with 7'h2a so an all-zero word does not encode to all-zero.
module prim_secded_inv_39_32_enc (
    input  logic [31:0] data_i,
    output logic [38:0] data_o
);

    logic [38:0] raw;

    always_comb begin
        raw     = {7'h00, data_i};
        raw[32] = ^(raw & 39'h002606BD25);
        raw[33] = ^(raw & 39'h00DEBA8050);
        raw[34] = ^(raw & 39'h00413D89AA);
        raw[35] = ^(raw & 39'h0031234ED1);
        raw[36] = ^(raw & 39'h00C2C1323B);
        raw[37] = ^(raw & 39'h002DCC624C);
        raw[38] = ^(raw & 39'h0098505586);
        data_o  = raw ^ 39'h2A00000000;
    end

endmodule

// File: rtl/cheri_trvk_sched.sv
// Reserves capability-load destinations (trsv) and releases them via trvk after a revocation-bitmap lookup.
// Latency: trsv same cycle as accept; trvk 3 cycles after pop with immediate grant, 1 cycle on bypass.
// Backpressure: ldcap_ready_o low when queue full or rd pending; CHERI_TRVK_TIMEOUT_EN adds a fail-safe watchdog.
module cheri_trvk_sched
    import cheri_pkg::*;
#(
    parameter int unsigned Depth         = 4,
    parameter logic [31:0] HeapBase      = 32'h8000_0000,
    parameter logic [31:0] HeapSize      = 32'h0004_0000,
    parameter logic [31:0] RvkBase       = 32'h8300_0000,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ldcap_valid_i,
    output logic        ldcap_ready_o,
    input  logic [4:0]  ldcap_rd_i,
    input  logic [31:0] ldcap_base_i,
    input  logic        ldcap_tag_i,
    output logic [4:0]  trsv_addr_o,
    output logic        trsv_en_o,
    output logic [6:0]  trsv_par_o,
    output logic [4:0]  trvk_addr_o,
    output logic        trvk_en_o,
    output logic        trvk_clrtag_o,
    output logic [6:0]  trvk_par_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o,
    output logic        alert_o
);

    trvk_sched_state_e state_q, state_d;
    rvk_entry_t        infl_q, infl_d, head, push_dat;
    logic              clrtag_q, clrtag_d;
    logic              full, empty, push, pop, infl_match, tmo_hit;
    logic [Depth-1:0]  match;
    logic [31:0]       ld_off, infl_off, bitidx, bm_addr;
    logic [31:0]       unused_trsv_dat, unused_trvk_dat;

    // An in-flight entry still owns its rd until the trvk cycle has passed.
    assign infl_match    = (state_q != IDLE) && (infl_q.rd == ldcap_rd_i);
    assign ldcap_ready_o = !full && !(|match) && !infl_match;
    assign push          = ldcap_valid_i && ldcap_ready_o && (ldcap_rd_i != 5'd0);
    assign pop           = (state_q == IDLE) && !empty;

    assign ld_off           = ldcap_base_i - HeapBase;
    assign push_dat.rd      = ldcap_rd_i;
    assign push_dat.base    = ldcap_base_i;
    assign push_dat.tag     = ldcap_tag_i;
    assign push_dat.inrange = (ld_off < HeapSize);

    cheri_trvk_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .match_rd (ldcap_rd_i),
        .match    (match)
    );

    // One bitmap bit per 8-byte granule, 32 granules per bitmap word.
    assign infl_off = infl_q.base - HeapBase;
    assign bitidx   = infl_off >> 3;
    assign bm_addr  = RvkBase + {3'b000, bitidx[31:5], 2'b00};

    always_comb begin
        state_d   = state_q;
        infl_d    = infl_q;
        clrtag_d  = clrtag_q;
        mem_req_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    infl_d   = head;
                    clrtag_d = 1'b0;
                    state_d  = (head.tag && head.inrange) ? REQ : RVK;
                end
            end
            REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    clrtag_d = mem_rdata_i[bitidx[4:0]];
                    state_d  = RVK;
                end
            end
            RVK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (tmo_hit) begin
            clrtag_d = 1'b1;
            state_d  = RVK;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            infl_q   <= '0;
            clrtag_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            infl_q   <= infl_d;
            clrtag_q <= clrtag_d;
        end
    end

`ifdef CHERI_TRVK_TIMEOUT_EN
    localparam int unsigned CntW = 16;

    logic [CntW-1:0] tmo_cnt_q;
    logic            tmo_run, alert_q;

    assign tmo_run = (state_q == REQ) || (state_q == WAIT);
    // A response arriving on the limit cycle still wins over the watchdog.
    assign tmo_hit = (tmo_cnt_q >= CntW'(TimeoutCycles - 1))
                  && (((state_q == REQ) && !mem_gnt_i) || ((state_q == WAIT) && !mem_rvalid_i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
            alert_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_run ? tmo_cnt_q + 1'b1 : '0;
            if (tmo_hit) begin
                alert_q <= 1'b1;
            end
        end
    end

    assign alert_o = alert_q;
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign alert_o    = 1'b0;
    assign unused_tmo = (TimeoutCycles != 0);
`endif

    assign trsv_en_o     = push;
    assign trsv_addr_o   = push ? ldcap_rd_i : 5'd0;
    assign trvk_en_o     = (state_q == RVK);
    assign trvk_addr_o   = trvk_en_o ? infl_q.rd : 5'd0;
    assign trvk_clrtag_o = trvk_en_o && clrtag_q;
    assign mem_addr_o    = mem_req_o ? bm_addr : 32'd0;
    assign busy_o        = !empty || (state_q != IDLE);

    prim_secded_inv_39_32_enc u_trsv_enc (
        .data_i ({26'h0, trsv_en_o, trsv_addr_o}),
        .data_o ({trsv_par_o, unused_trsv_dat})
    );

    prim_secded_inv_39_32_enc u_trvk_enc (
        .data_i ({25'h0, trvk_en_o, trvk_clrtag_o, trvk_addr_o}),
        .data_o ({trvk_par_o, unused_trvk_dat})
    );

endmodule

// File: tb/tb_cheri_trvk_sched.sv
// Directed and randomized bench for cheri_trvk_sched against a queue-based reference model.
// Memory side is a bitmap array answering req/gnt/rvalid with configurable grant behaviour.
module tb_cheri_trvk_sched;
    import cheri_pkg::*;

    localparam int          Depth    = 4;
    localparam logic [31:0] HeapBase = 32'h8000_0000;
    localparam logic [31:0] HeapSize = 32'h0004_0000;
    localparam logic [31:0] RvkBase  = 32'h8300_0000;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ldcap_valid_i = 1'b0;
    logic        ldcap_ready_o;
    logic [4:0]  ldcap_rd_i = '0;
    logic [31:0] ldcap_base_i = '0;
    logic        ldcap_tag_i = 1'b0;
    logic [4:0]  trsv_addr_o;
    logic        trsv_en_o;
    logic [6:0]  trsv_par_o;
    logic [4:0]  trvk_addr_o;
    logic        trvk_en_o;
    logic        trvk_clrtag_o;
    logic [6:0]  trvk_par_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        busy_o;
    logic        alert_o;

    always #5 clk_i = ~clk_i;

    cheri_trvk_sched #(
        .Depth         (Depth),
        .HeapBase      (HeapBase),
        .HeapSize      (HeapSize),
        .RvkBase       (RvkBase),
        .TimeoutCycles (255)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .ldcap_valid_i (ldcap_valid_i),
        .ldcap_ready_o (ldcap_ready_o),
        .ldcap_rd_i    (ldcap_rd_i),
        .ldcap_base_i  (ldcap_base_i),
        .ldcap_tag_i   (ldcap_tag_i),
        .trsv_addr_o   (trsv_addr_o),
        .trsv_en_o     (trsv_en_o),
        .trsv_par_o    (trsv_par_o),
        .trvk_addr_o   (trvk_addr_o),
        .trvk_en_o     (trvk_en_o),
        .trvk_clrtag_o (trvk_clrtag_o),
        .trvk_par_o    (trvk_par_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .busy_o        (busy_o),
        .alert_o       (alert_o)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        clr;
        logic        mem;
        logic [31:0] maddr;
        int          acc_cyc;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] bm [1024];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          gnt_mode = 0;   // 0 immediate, 1 held low, 2 random
    bit          rv_en    = 1'b1;
    bit          rd_pend  = 1'b0;
    logic [31:0] rd_addr;
    int          rd_dly   = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_maddr;
    int          last_trvk_cyc = -1;
    int          last_acc_cyc  = -1;
    int          last_lat      = 0;
    logic [31:0] last_maddr    = '0;
    logic        last_clr      = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_par(input logic [31:0] d);
        logic [6:0] p;
        p[0] = ^(d & 32'h2606BD25);
        p[1] = ^(d & 32'hDEBA8050);
        p[2] = ^(d & 32'h413D89AA);
        p[3] = ^(d & 32'h31234ED1);
        p[4] = ^(d & 32'hC2C1323B);
        p[5] = ^(d & 32'h2DCC624C);
        p[6] = ^(d & 32'h98505586);
        return p ^ 7'h2a;
    endfunction

    function automatic exp_t model(input logic [4:0] rd, input logic [31:0] base, input logic tag);
        exp_t        e;
        logic [31:0] off;
        int          w;
        int          b;
        off      = base - HeapBase;
        e.rd     = rd;
        e.mem    = tag && (off < HeapSize);
        w        = int'(off / 256);
        b        = int'((off / 8) % 32);
        e.maddr  = RvkBase + 32'(w) * 4;
        e.clr    = e.mem ? bm[w][b] : 1'b0;
        e.acc_cyc = cyc;
        return e;
    endfunction

    function automatic logic [31:0] bm_rd(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - RvkBase) / 4;
        if (idx < 1024) return bm[idx];
        return $urandom();
    endfunction

    task automatic cycle(input logic vld, input logic [4:0] rd, input logic [31:0] base,
                         input logic tag, output logic acc);
        bit hit;
        mem_gnt_i    = mem_req_o && ((gnt_mode == 0) || ((gnt_mode == 2) && ($urandom_range(0, 2) == 0)));
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom();
        if (rd_pend && rv_en && (rd_dly == 0)) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = bm_rd(rd_addr);
        end
        ldcap_valid_i = vld;
        ldcap_rd_i    = rd;
        ldcap_base_i  = base;
        ldcap_tag_i   = tag;
        #1;
        check("busy", busy_o, expq.size() != 0);
`ifndef CHERI_TRVK_TIMEOUT_EN
        check("alert_tied", alert_o, 0);
`endif
        check("trsv_par", trsv_par_o, ref_par({26'h0, trsv_en_o, trsv_addr_o}));
        check("trvk_par", trvk_par_o, ref_par({25'h0, trvk_en_o, trvk_clrtag_o, trvk_addr_o}));
        if (vld) begin
            hit = 1'b0;
            foreach (expq[i]) if (expq[i].rd == rd) hit = 1'b1;
            if (hit || (expq.size() > Depth)) check("ready_block", ldcap_ready_o, 0);
            else if (expq.size() == 0) check("ready_empty", ldcap_ready_o, 1);
        end
        acc = vld && ldcap_ready_o;
        check("trsv_en", trsv_en_o, acc && (rd != 5'd0));
        if (acc && (rd != 5'd0)) check("trsv_addr", trsv_addr_o, rd);
        if (prev_stall) begin
            check("req_hold", mem_req_o, 1);
            check("addr_hold", mem_addr_o, prev_maddr);
        end
        if (mem_req_o) begin
            if (expq.size() == 0) check("req_unexpected", mem_req_o, 0);
            else begin
                check("req_bypass", mem_req_o, expq[0].mem);
                check("mem_addr", mem_addr_o, expq[0].maddr);
                last_maddr = mem_addr_o;
            end
        end
        if (trvk_en_o) begin
            if (expq.size() == 0) check("trvk_unexpected", trvk_en_o, 0);
            else begin
                check("trvk_addr", trvk_addr_o, expq[0].rd);
                check("trvk_clr", trvk_clrtag_o, expq[0].clr);
                last_lat      = cyc - expq[0].acc_cyc;
                last_trvk_cyc = cyc;
                last_clr      = trvk_clrtag_o;
                void'(expq.pop_front());
            end
        end
        if (acc && (rd != 5'd0)) begin
            expq.push_back(model(rd, base, tag));
            last_acc_cyc = cyc;
        end
        prev_stall = mem_req_o && !mem_gnt_i;
        prev_maddr = mem_addr_o;
        if (mem_rvalid_i) rd_pend = 1'b0;
        else if (rd_pend && (rd_dly > 0)) rd_dly--;
        if (mem_req_o && mem_gnt_i) begin
            rd_pend = 1'b1;
            rd_addr = mem_addr_o;
            rd_dly  = (gnt_mode == 2) ? $urandom_range(0, 2) : 0;
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget);
        logic a;
        int   n;
        n = 0;
        while ((expq.size() != 0) && (n < budget)) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, a);
            n++;
        end
        check("drain_done", expq.size(), 0);
    endtask

    task automatic send(input logic [4:0] rd, input logic [31:0] base, input logic tag, input int budget);
        logic a;
        int   n;
        a = 1'b0;
        n = 0;
        while (!a && (n < budget)) begin
            cycle(1'b1, rd, base, tag, a);
            n++;
        end
        check("send_accepted", a, 1);
    endtask

    task automatic do_reset();
        rst_ni        = 1'b0;
        ldcap_valid_i = 1'b0;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        expq.delete();
        rd_pend       = 1'b0;
        prev_stall    = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", ldcap_ready_o, 1);
        check("rst_trsv_en", trsv_en_o, 0);
        check("rst_trsv_addr", trsv_addr_o, 0);
        check("rst_trvk_en", trvk_en_o, 0);
        check("rst_trvk_addr", trvk_addr_o, 0);
        check("rst_trvk_clr", trvk_clrtag_o, 0);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_alert", alert_o, 0);
        check("rst_trsv_par", trsv_par_o, 7'h2a);
        check("rst_trvk_par", trvk_par_o, 7'h2a);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic        a;
        int          acc_n;
        int          nxt;
        int          n;
        logic [31:0] base;
        for (int i = 0; i < 1024; i++) bm[i] = $urandom();
        do_reset();

        // Bitmap bit clear: granule 8 of word 0
        bm[0] = 32'h0;
        send(5'd5, 32'h8000_0040, 1'b1, 4);
        drain(20);
        check("bitclr_maddr", last_maddr, 32'h8300_0000);
        check("bitclr_clr", last_clr, 0);
        check("bitclr_lat", last_lat, 4);

        // Bitmap bit set: bitidx 33 -> word 1, bit 1
        bm[1] = 32'h2;
        send(5'd7, 32'h8000_0108, 1'b1, 4);
        drain(20);
        check("bitset_maddr", last_maddr, 32'h8300_0004);
        check("bitset_clr", last_clr, 1);

        // Bypass paths: outside heap, and untagged
        send(5'd9, 32'h2000_0000, 1'b1, 4);
        drain(10);
        check("byp_oor_lat", last_lat <= 2, 1);
        check("byp_oor_clr", last_clr, 0);
        send(5'd10, 32'h8000_0100, 1'b0, 4);
        drain(10);
        check("byp_untag_lat", last_lat <= 2, 1);

        // Heap edges
        bm[1023] = 32'hFFFF_FFFF;
        send(5'd11, HeapBase + HeapSize - 1, 1'b1, 4);
        drain(20);
        check("edge_hi_maddr", last_maddr, 32'h8300_0FFC);
        check("edge_hi_clr", last_clr, 1);
        send(5'd12, HeapBase + HeapSize, 1'b1, 4);
        drain(10);
        check("edge_past_clr", last_clr, 0);
        send(5'd13, HeapBase - 1, 1'b1, 4);
        drain(10);
        check("edge_below_clr", last_clr, 0);
        check("idle_trsv_par", trsv_par_o, 7'h2a);

        // Delayed grant with a same-rd load stalled behind it
        gnt_mode = 1;
        send(5'd5, 32'h8000_0040, 1'b1, 4);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 5'd5, 32'h8000_0040, 1'b1, a);
            check("samerd_stall", a, 0);
        end
        gnt_mode = 0;
        send(5'd5, 32'h8000_0040, 1'b1, 20);
        check("samerd_release", last_acc_cyc, last_trvk_cyc + 1);
        drain(20);

        // Fill: in-flight entry plus Depth queued entries, grant held off
        gnt_mode = 1;
        acc_n = 0;
        nxt = 1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 5'(nxt), HeapBase + 32'(nxt) * 64, 1'b1, a);
            if (a) begin
                acc_n++;
                nxt++;
            end
        end
        check("full_accepts", acc_n, Depth + 1);
        gnt_mode = 0;
        drain(100);

        // Randomized traffic with random grant and response delays
        gnt_mode = 2;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0:       base = $urandom();
                1:       base = HeapBase + HeapSize - 32'($urandom_range(1, 8));
                2:       base = HeapBase + HeapSize + 32'($urandom_range(0, 7));
                default: base = HeapBase + ($urandom() % HeapSize);
            endcase
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), base,
                  1'($urandom_range(0, 3) != 0), a);
        end
        drain(300);
        gnt_mode = 0;

`ifdef CHERI_TRVK_TIMEOUT_EN
        // Watchdog: granted read never answered
        rv_en = 1'b0;
        bm[0] = 32'h0;
        send(5'd3, HeapBase, 1'b1, 4);
        expq[0].clr = 1'b1;
        n = 0;
        while (!alert_o && (n < 400)) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, a);
            n++;
        end
        check("tmo_alert", alert_o, 1);
        drain(10);
        check("tmo_clr", last_clr, 1);
        repeat (5) cycle(1'b0, 5'd0, 32'd0, 1'b0, a);
        check("tmo_sticky", alert_o, 1);
        rv_en = 1'b1;
        do_reset();
        check("tmo_cleared", alert_o, 0);
`else
        n = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
